bram_access_arbiter: RTL

- Shares one single-port block RAM (blk_mem_gen_0: ena/wea/addra/dina/douta) between two independent requesters, e.g. an image loader and a pixel-fetch/processing unit.
- Performs round-robin arbitration, one access per clock, and routes read data back to the requester that issued it, after the RAM read latency.
- Contains a clear engine that fills the whole RAM with a constant value; requesters are blocked while it runs.

---
 rtl/bram_access_arbiter_if.sv | 59 +++++
 rtl/bram_access_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bram_access_arbiter_if.sv
// Bundles the signals of the BRAM access arbiter into one interface.
// Port summary:
//   clear_start / clear_busy / clear_done : clear engine control and status
//   r0_* / r1_*  : requester handshakes (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   mem_*        : single-port block RAM connection (en/we/addr/din out, dout in)
// The slave modport is the arbiter. The master modport is the surrounding
// system: the requesters, the clear controller and the RAM.
interface bram_access_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              clear_start;
   logic              clear_busy;
   logic              clear_done;

   logic              r0_req;
   logic              r0_we;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_gnt;
   logic              r0_rvalid;
   logic [DATA_W-1:0] r0_rdata;

   logic              r1_req;
   logic              r1_we;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_gnt;
   logic              r1_rvalid;
   logic [DATA_W-1:0] r1_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport slave (
      input  clear_start,
      output clear_busy, clear_done,
      input  r0_req, r0_we, r0_addr, r0_wdata,
      output r0_gnt, r0_rvalid, r0_rdata,
      input  r1_req, r1_we, r1_addr, r1_wdata,
      output r1_gnt, r1_rvalid, r1_rdata,
      output mem_en, mem_we, mem_addr, mem_din,
      input  mem_dout
   );

   modport master (
      output clear_start,
      input  clear_busy, clear_done,
      output r0_req, r0_we, r0_addr, r0_wdata,
      input  r0_gnt, r0_rvalid, r0_rdata,
      output r1_req, r1_we, r1_addr, r1_wdata,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  mem_en, mem_we, mem_addr, mem_din,
      output mem_dout
   );
endinterface

// File: rtl/bram_access_arbiter.sv
// Shares one single-port block RAM between two requesters.
// Access to the RAM is granted round-robin, one access per clock. Read data is
// steered back to the requester that issued the read, READ_LATENCY cycles later.
// A clear engine can take over the RAM and write CLEAR_VALUE to every address.
// Port summary:
//   clk   : system clock; all state changes on the rising edge
//   rst_n : asynchronous, active-low reset
//   bus   : slave modport of bram_access_arbiter_if (requesters, clear, RAM)
module bram_access_arbiter #(
   parameter int              ADDR_W       = 13,
   parameter int              DATA_W       = 8,
   parameter int              READ_LATENCY = 1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
   input logic                  clk,
   input logic                  rst_n,
   bram_access_arbiter_if.slave bus
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {ST_ARB, ST_CLEAR} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       cnt_q, cnt_d;
   logic                    last_grant_q, last_grant_d;
   logic                    clear_done_q, clear_done_d;
   // Read-tag pipeline: one {valid, id} entry per cycle of RAM read latency.
   logic [READ_LATENCY-1:0] tag_valid_q, tag_valid_d;
   logic [READ_LATENCY-1:0] tag_id_q, tag_id_d;

   logic                    gnt0;
   logic                    gnt1;
   logic                    rd_issue;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      clear_done_d = 1'b0;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      bus.mem_en   = 1'b0;
      bus.mem_we   = 1'b0;
      bus.mem_addr = '0;
      bus.mem_din  = '0;

      case (state_q)
         ST_ARB: begin
            // On a tie the port that was not granted last wins.
            if (bus.r0_req && bus.r1_req) begin
               gnt0 = last_grant_q;
               gnt1 = ~last_grant_q;
            end else begin
               gnt0 = bus.r0_req;
               gnt1 = bus.r1_req;
            end
            // Grants are combinational, so hold them low while reset is applied.
            gnt0 = gnt0 & rst_n;
            gnt1 = gnt1 & rst_n;

            if (gnt0) begin
               bus.mem_en   = 1'b1;
               bus.mem_we   = bus.r0_we;
               bus.mem_addr = bus.r0_addr;
               bus.mem_din  = bus.r0_wdata;
            end else if (gnt1) begin
               bus.mem_en   = 1'b1;
               bus.mem_we   = bus.r1_we;
               bus.mem_addr = bus.r1_addr;
               bus.mem_din  = bus.r1_wdata;
            end

            if (gnt0 || gnt1) begin
               last_grant_d = gnt1;
            end

            if (bus.clear_start) begin
               state_d = ST_CLEAR;
            end
         end

         ST_CLEAR: begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = 1'b1;
            bus.mem_addr = cnt_q;
            bus.mem_din  = CLEAR_VALUE;
            // Natural overflow brings the counter back to 0 after the last word.
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d      = ST_ARB;
               clear_done_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_ARB;
         end
      endcase

      rd_issue = (gnt0 & ~bus.r0_we) | (gnt1 & ~bus.r1_we);

      tag_valid_d    = '0;
      tag_id_d       = '0;
      tag_valid_d[0] = rd_issue;
      tag_id_d[0]    = gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
         tag_valid_d[i] = tag_valid_q[i-1];
         tag_id_d[i]    = tag_id_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ARB;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         clear_done_q <= 1'b0;
         tag_valid_q  <= '0;
         tag_id_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         clear_done_q <= clear_done_d;
         tag_valid_q  <= tag_valid_d;
         tag_id_q     <= tag_id_d;
      end
   end

   assign bus.r0_gnt     = gnt0;
   assign bus.r1_gnt     = gnt1;
   assign bus.r0_rvalid  = tag_valid_q[READ_LATENCY-1] & ~tag_id_q[READ_LATENCY-1];
   assign bus.r1_rvalid  = tag_valid_q[READ_LATENCY-1] &  tag_id_q[READ_LATENCY-1];
   assign bus.r0_rdata   = bus.mem_dout;
   assign bus.r1_rdata   = bus.mem_dout;
   assign bus.clear_busy = (state_q == ST_CLEAR);
   assign bus.clear_done = clear_done_q;
endmodule
